// File: rtl/mem_pipe_responder.sv
`default_nettype none
// ============================================================================
// mem_pipe_responder : pipelined fixed-latency memory responder; optional
// misaligned-request rejection with err strobe via MEM_RESP_ERR_EN.  Rev 1.0
// ============================================================================
module mem_pipe_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CARRY = 1'b1
  } stage_e;

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  stage_e                stage_q [LATENCY];
  stage_e                stage_d [LATENCY];
  logic [ADDR_WIDTH-1:0] paddr_q [LATENCY];
  logic [ADDR_WIDTH-1:0] paddr_d [LATENCY];
  logic [DATA_WIDTH-1:0] pdata_q [LATENCY];
  logic [DATA_WIDTH-1:0] pdata_d [LATENCY];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  busy_q;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_misaligned;
  logic                  w_rd_issue;
  logic                  w_wr_commit;
  logic                  w_rd_done;

  assign w_idx = addr[DEPTH_LOG2:1];
`ifdef MEM_RESP_ERR_EN
  assign w_misaligned = addr[0];
`else
  assign w_misaligned = 1'b0;
`endif
  assign w_rd_issue  = enable & ~wr & ~w_misaligned;
  // A request coinciding with reset must not touch storage.
  assign w_wr_commit = rst_n & enable & wr & ~w_misaligned;
  assign w_rd_done   = (stage_q[LATENCY-1] == ST_CARRY);

  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      mem_q[w_idx] <= data_in;
    end
  end

  // Idle stages carry zero payload so the outputs read 0 without extra gating.
  always_comb begin
    stage_d[0] = w_rd_issue ? ST_CARRY : ST_IDLE;
    paddr_d[0] = w_rd_issue ? addr : '0;
    pdata_d[0] = w_rd_issue ? mem_q[w_idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
      paddr_d[i] = paddr_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
    count_d = count_q + CNT_W'(w_rd_issue) - CNT_W'(w_rd_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= ST_IDLE;
        paddr_q[i] <= '0;
        pdata_q[i] <= '0;
      end
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      count_q <= count_d;
      busy_q  <= (count_d != '0);
    end
  end

`ifdef MEM_RESP_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= enable & w_misaligned;
    end
  end

  assign err = err_q;
`endif

  assign data_valid = (stage_q[LATENCY-1] == ST_CARRY);
  assign data_out   = pdata_q[LATENCY-1];
  assign resp_addr  = paddr_q[LATENCY-1];
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_pipe_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_pipe_responder : directed + random stimulus against a queue-based
// reference model of the memory responder.  Rev 1.0
// ============================================================================
module tb_mem_pipe_responder;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DL  = 10;
  localparam int LAT = 4;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [AW-1:0] resp_addr;
  logic          busy;
`ifdef MEM_RESP_ERR_EN
  logic          err;
`endif

  mem_pipe_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .resp_addr (resp_addr),
    .busy      (busy)
`ifdef MEM_RESP_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } resp_t;

  logic [DW-1:0] ref_mem [2**DL];
  resp_t         exp_q [$];
  int            edge_n = 0;
  bit            err_exp = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One clock: drive, let the model consume the sampling edge, then compare.
  task automatic step(input bit rn, input bit en, input bit w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit    mis;
    resp_t r;
    rst_n   = rn;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    edge_n++;
    if (!rn) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      mis     = ERR_BUILD && a[0];
      err_exp = en && mis;
      if (en && !mis) begin
        if (w) ref_mem[a[DL:1]] = d;
        else   exp_q.push_back('{due: edge_n + LAT - 1, a: a, d: ref_mem[a[DL:1]]});
      end
    end
    #1;
    check_val("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
      r = exp_q.pop_front();
      check_val("data_valid", 32'(data_valid), 32'd1);
      check_val("data_out", 32'(data_out), 32'(r.d));
      check_val("resp_addr", 32'(resp_addr), 32'(r.a));
    end else begin
      check_val("data_valid_idle", 32'(data_valid), 32'd0);
      check_val("data_out_idle", 32'(data_out), 32'd0);
      check_val("resp_addr_idle", 32'(resp_addr), 32'd0);
    end
`ifdef MEM_RESP_ERR_EN
    check_val("err", 32'(err), 32'(err_exp));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  logic [AW-1:0] ra;
  logic [DW-1:0] rd;

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hDEAD);   // dropped: issued under reset

    // Write then immediate read of the same word.
    step(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b1, 1'b0, 16'h0010, '0);
    idle(LAT + 2);

    // Streamed block fill.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 16'(2 * i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'(2 * i), '0);
    idle(LAT + 2);

    // Read in flight must not see a later write to the same word.
    step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h1111);
    step(1'b1, 1'b1, 1'b0, 16'h0020, '0);
    step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h2222);
    step(1'b1, 1'b1, 1'b0, 16'h0020, '0);
    idle(LAT + 2);

    // Reset while two reads are outstanding; storage survives.
    step(1'b1, 1'b1, 1'b0, 16'h0002, '0);
    step(1'b1, 1'b1, 1'b0, 16'h0004, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    idle(LAT + 1);
    step(1'b1, 1'b1, 1'b0, 16'h0002, '0);
    step(1'b1, 1'b1, 1'b0, 16'h0010, '0);
    idle(LAT + 1);

    // Odd address: rejected with err, or aliased onto the even word.
    step(1'b1, 1'b1, 1'b1, 16'h0030, 16'h5555);
    step(1'b1, 1'b1, 1'b1, 16'h0031, 16'hAAAA);
    step(1'b1, 1'b1, 1'b0, 16'h0030, '0);
    step(1'b1, 1'b1, 1'b0, 16'hF831, '0);
    idle(LAT + 1);

    // Alternating write/read plus aliasing through the upper address bits.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 16'(4 * i), 16'($urandom));
      step(1'b1, 1'b1, 1'b0, 16'(4 * i) | 16'h8000, '0);
    end
    idle(LAT + 1);

    // Random traffic confined to pre-written words, with rare resets.
    for (int n = 0; n < 800; n++) begin
      ra = 16'($urandom) & 16'hF83F;
      rd = 16'($urandom);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, ra, rd);
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
